// File: rtl/tfab_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tfab_stream_pkg
// Purpose  : Shared types and constants for the ternary result streamer.
//            Holds the packet FSM state encoding, the header magic word and
//            the header length in beats.
// Revision : 1.0 - initial release
// ============================================================================
package tfab_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_DATA    = 2'd2,
    S_TRAILER = 2'd3
  } stream_state_t;

  localparam logic [15:0] TFAB_STREAM_MAGIC = 16'h5446;
  localparam int          TFAB_HDR_WORDS    = 4;

endpackage
`default_nettype wire

// File: rtl/ternary_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : ternary_result_streamer_if
// Purpose  : 32-bit AXI4-Stream style link carrying result packets.
// Ports    : tdata  - beat payload
//            tvalid - payload valid (master)
//            tready - sink ready (slave)
//            tlast  - final beat of packet
// Modports : master (streamer side), slave (sink side)
// Revision : 1.0 - initial release
// ============================================================================
interface ternary_result_streamer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/tfab_next_tile.sv
`default_nettype none
// ============================================================================
// Module   : tfab_next_tile
// Purpose  : Combinational finder for the lowest enabled tile whose index is
//            at or above from_idx. Pass current+1 to step to the next tile,
//            or 0 to find the first one.
// Ports    : mask     - enabled tiles
//            from_idx - lowest index considered
//            next_idx - index of the enabled tile found (0 when none)
//            none     - no enabled tile at or above from_idx
// Revision : 1.0 - initial release
// ============================================================================
module tfab_next_tile #(
  parameter int NUM_TILES = 4,
  parameter int IDXW      = 3
) (
  input  logic [NUM_TILES-1:0] mask,
  input  logic [IDXW-1:0]      from_idx,
  output logic [IDXW-1:0]      next_idx,
  output logic                 none
);

  // Scanning downward lets the lowest qualifying index win.
  always_comb begin
    next_idx = '0;
    none     = 1'b1;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (mask[i] && (IDXW'(i) >= from_idx)) begin
        next_idx = IDXW'(i);
        none     = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ternary_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : ternary_result_streamer
// Purpose  : Snapshots per-tile accumulator results on start and streams them
//            as one packet: 4 header beats, then the lanes of each enabled
//            tile in ascending order. Starts arriving while busy are counted.
// Ports    : clk, reset_n (async, active low)
//            start, tile_mask, vector_results, cycle_count - packet request
//            m_axis  - result stream (master modport)
//            busy    - packet pending or in flight
//            drop_count - saturating count of ignored starts
// Config   : TFAB_STREAM_CHECKSUM_EN - append a checksum trailer beat
// Revision : 1.0 - initial release
// ============================================================================
module ternary_result_streamer
  import tfab_stream_pkg::*;
#(
  parameter int LANES     = 15,
  parameter int NUM_TILES = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [NUM_TILES-1:0]         tile_mask,
  input  logic [NUM_TILES*LANES*32-1:0] vector_results,
  input  logic [31:0]                  cycle_count,
  ternary_result_streamer_if.master    m_axis,
  output logic                         busy,
  output logic [15:0]                  drop_count
);

  localparam int IDXW = $clog2(NUM_TILES) + 1;  // room for "one past last"
  localparam int LW   = $clog2(LANES + 1);

  stream_state_t state, next_state;

  logic [NUM_TILES*LANES*32-1:0] snap_vec;
  logic [NUM_TILES-1:0]          snap_mask;
  logic [31:0]                   snap_cycles;
  logic [31:0]                   seq;
  logic [1:0]                    hdr_idx;
  logic [IDXW-1:0]               tile_idx, search_from, next_tile;
  logic [LW-1:0]                 lane_idx;
  logic                          no_tile;
  logic                          pending;   // start taken on the final beat
  logic                          fire, take, done, hdr_last, last_lane;
`ifdef TFAB_STREAM_CHECKSUM_EN
  logic [31:0]                   csum;
`endif

  function automatic logic [31:0] popcount(input logic [NUM_TILES-1:0] m);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUM_TILES; i++) n = n + 32'(m[i]);
    return n;
  endfunction

  assign fire        = m_axis.tvalid && m_axis.tready;
  assign hdr_last    = (hdr_idx == 2'(TFAB_HDR_WORDS - 1));
  assign last_lane   = (lane_idx == LW'(LANES - 1));
  assign search_from = (state == S_DATA) ? tile_idx + IDXW'(1) : '0;
  assign busy        = (state != S_IDLE) || pending;

  tfab_next_tile #(
    .NUM_TILES (NUM_TILES),
    .IDXW      (IDXW)
  ) u_next_tile (
    .mask     (snap_mask),
    .from_idx (search_from),
    .next_idx (next_tile),
    .none     (no_tile)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          next_state = S_HEADER;
        end else if (start) begin
          take       = 1'b1;
          next_state = S_HEADER;
        end
      end
      S_HEADER: begin
        if (fire && hdr_last) begin
          if (snap_mask != '0) next_state = S_DATA;
`ifdef TFAB_STREAM_CHECKSUM_EN
          else                 next_state = S_TRAILER;
`else
          else                 done = 1'b1;
`endif
        end
      end
      S_DATA: begin
        if (fire && last_lane && no_tile) begin
`ifdef TFAB_STREAM_CHECKSUM_EN
          next_state = S_TRAILER;
`else
          done = 1'b1;
`endif
        end
      end
`ifdef TFAB_STREAM_CHECKSUM_EN
      S_TRAILER: if (fire) done = 1'b1;
`endif
      default: next_state = S_IDLE;
    endcase
    // A start coinciding with the final beat is snapshotted now and launched
    // after one idle cycle.
    if (done) begin
      next_state = S_IDLE;
      take       = start;
    end
  end

  always_comb begin
    m_axis.tvalid = (state != S_IDLE);
    m_axis.tdata  = '0;
    m_axis.tlast  = 1'b0;
    case (state)
      S_HEADER: begin
        case (hdr_idx)
          2'd0:    m_axis.tdata = {TFAB_STREAM_MAGIC, 16'(snap_mask)};
          2'd1:    m_axis.tdata = popcount(snap_mask) * 32'(LANES);
          2'd2:    m_axis.tdata = snap_cycles;
          default: m_axis.tdata = seq;
        endcase
`ifndef TFAB_STREAM_CHECKSUM_EN
        m_axis.tlast = hdr_last && (snap_mask == '0);
`endif
      end
      S_DATA: begin
        m_axis.tdata = snap_vec[(int'(tile_idx) * LANES + int'(lane_idx)) * 32 +: 32];
`ifndef TFAB_STREAM_CHECKSUM_EN
        m_axis.tlast = last_lane && no_tile;
`endif
      end
`ifdef TFAB_STREAM_CHECKSUM_EN
      S_TRAILER: begin
        m_axis.tdata = csum;
        m_axis.tlast = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_vec    <= '0;
      snap_mask   <= '0;
      snap_cycles <= '0;
      seq         <= '0;
      hdr_idx     <= '0;
      tile_idx    <= '0;
      lane_idx    <= '0;
      pending     <= 1'b0;
      drop_count  <= '0;
`ifdef TFAB_STREAM_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      if (fire) begin
        case (state)
          S_HEADER: begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_last) begin
              tile_idx <= next_tile;
              lane_idx <= '0;
            end
          end
          S_DATA: begin
            if (last_lane) begin
              lane_idx <= '0;
              if (!no_tile) tile_idx <= next_tile;
            end else begin
              lane_idx <= lane_idx + LW'(1);
            end
          end
          default: ;
        endcase
      end
`ifdef TFAB_STREAM_CHECKSUM_EN
      if (fire && (state == S_HEADER || state == S_DATA))
        csum <= csum + m_axis.tdata;
`endif
      if (take) begin
        snap_vec    <= vector_results;
        snap_mask   <= tile_mask;
        snap_cycles <= cycle_count;
        hdr_idx     <= '0;
`ifdef TFAB_STREAM_CHECKSUM_EN
        csum        <= '0;
`endif
      end
      pending <= done && start;
      if (done) seq <= seq + 32'd1;
      if (start && busy && !done && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ternary_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ternary_result_streamer
// Purpose  : Directed self-checking bench for ternary_result_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_result_streamer;

  localparam int LANES = 15;
  localparam int NT    = 4;
`ifdef TFAB_STREAM_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic [NT-1:0]          tile_mask;
  logic [NT*LANES*32-1:0] vector_results;
  logic [31:0]            cycle_count;
  logic                   busy;
  logic [15:0]            drop_count;

  ternary_result_streamer_if axis ();

  ternary_result_streamer #(.LANES(LANES), .NUM_TILES(NT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .tile_mask      (tile_mask),
    .vector_results (vector_results),
    .cycle_count    (cycle_count),
    .m_axis         (axis),
    .busy           (busy),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_seq;
  logic [31:0] cap_data [$];
  logic        cap_last [$];
  logic [31:0] exp_q    [$];
  int          stall_err;

  task automatic fill_vectors();
    for (int t = 0; t < NT; t++)
      for (int l = 0; l < LANES; l++)
        vector_results[(t*LANES+l)*32 +: 32] = {16'(t), 16'(l)};
  endtask

  // Reference packet: header, enabled tiles' lanes, optional checksum.
  function automatic void build_expected(input logic [NT-1:0] m, input logic [31:0] cyc,
                                         input logic [31:0] sq);
    int          pc;
    logic [31:0] sum;
    exp_q.delete();
    pc = 0;
    for (int t = 0; t < NT; t++) if (m[t]) pc++;
    exp_q.push_back(32'h5446_0000 | 32'(m));
    exp_q.push_back(32'(pc * LANES));
    exp_q.push_back(cyc);
    exp_q.push_back(sq);
    for (int t = 0; t < NT; t++)
      if (m[t])
        for (int l = 0; l < LANES; l++) exp_q.push_back({16'(t), 16'(l)});
    if (CK == 1) begin
      sum = '0;
      foreach (exp_q[i]) sum = sum + exp_q[i];
      exp_q.push_back(sum);
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Collects one packet at the sink; optionally pulses start while busy.
  task automatic capture(input int duty, input int n_drop, input int max_cyc,
                         output bit timed_out);
    logic        stalled;
    logic [31:0] pd;
    logic        pl;
    cap_data.delete();
    cap_last.delete();
    stall_err = 0;
    timed_out = 1'b1;
    stalled   = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      axis.tready = ($urandom_range(0, 99) < duty);
      start = (n_drop > 0) && (c % 5 == 3) && (c / 5 < n_drop);
      if (stalled && (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tlast !== pl))
        stall_err++;
      stalled = axis.tvalid && !axis.tready;
      pd = axis.tdata;
      pl = axis.tlast;
      if (axis.tvalid && axis.tready) begin
        cap_data.push_back(axis.tdata);
        cap_last.push_back(axis.tlast);
        if (axis.tlast) begin
          timed_out = 1'b0;
          @(negedge clk);
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    axis.tready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; axis.tready = 1'b0;
    tile_mask = '0; cycle_count = '0; fill_vectors();
    repeat (2) @(negedge clk);
    tests++; if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got=%b exp=0", axis.tvalid); end
    tests++; if (axis.tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast got=%b exp=0", axis.tlast); end
    tests++; if (axis.tdata !== 32'h0) begin fails++; $display("FAIL reset_tdata got=%h exp=0", axis.tdata); end
    tests++; if (busy !== 1'b0 || drop_count !== 16'd0) begin fails++; $display("FAIL reset_status busy=%b drop=%0d exp 0/0", busy, drop_count); end
    reset_n = 1'b1;
    exp_seq = '0;
    @(negedge clk);
  endtask

  task automatic test_full_mask();
    bit to; int bad, nl, lp;
    tile_mask = 4'hF; cycle_count = 32'hC0DE_0001;
    build_expected(4'hF, 32'hC0DE_0001, exp_seq);
    pulse_start();
    tests++; if (axis.tvalid !== 1'b1) begin fails++; $display("FAIL full_latency tvalid=%b exp=1", axis.tvalid); end
    // Inputs changing after the snapshot must not leak into the packet.
    tile_mask = 4'h0; cycle_count = 32'hDEAD_BEEF; vector_results = ~vector_results;
    capture(100, 0, 500, to);
    fill_vectors();
    bad = 0; nl = 0; lp = -1;
    foreach (cap_data[i]) begin
      if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
      if (cap_last[i]) begin nl++; lp = i; end
    end
    tests++; if (to) begin fails++; $display("FAIL full_timeout no tlast"); end
    tests++; if (cap_data.size() != 64 + CK) begin fails++; $display("FAIL full_len got=%0d exp=%0d", cap_data.size(), 64 + CK); end
    tests++; if (cap_data[0] !== 32'h5446_000F || cap_data[1] !== 32'd60) begin fails++; $display("FAIL full_hdr H0=%h H1=%0d exp 5446000f/60", cap_data[0], cap_data[1]); end
    tests++; if (cap_data[2] !== 32'hC0DE_0001 || cap_data[3] !== 32'd0) begin fails++; $display("FAIL full_h2h3 H2=%h H3=%0d exp c0de0001/0", cap_data[2], cap_data[3]); end
    tests++; if (bad != 0) begin fails++; $display("FAIL full_data mismatched_words=%0d exp=0", bad); end
    tests++; if (nl != 1 || lp != 63 + CK) begin fails++; $display("FAIL full_tlast count=%0d pos=%0d exp 1/%0d", nl, lp, 63 + CK); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_after got=%b exp=0", busy); end
    exp_seq++;
  endtask

  task automatic test_sparse_mask();
    bit to; int bad, nl, lp;
    tile_mask = 4'b0101; cycle_count = 32'h0000_1234;
    build_expected(4'b0101, 32'h0000_1234, exp_seq);
    pulse_start();
    capture(100, 0, 500, to);
    bad = 0; nl = 0; lp = -1;
    foreach (cap_data[i]) begin
      if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
      if (cap_last[i]) begin nl++; lp = i; end
    end
    tests++; if (to || cap_data.size() != 34 + CK) begin fails++; $display("FAIL sparse_len got=%0d exp=%0d", cap_data.size(), 34 + CK); end
    tests++; if (cap_data[0] !== 32'h5446_0005 || cap_data[1] !== 32'd30) begin fails++; $display("FAIL sparse_hdr H0=%h H1=%0d exp 54460005/30", cap_data[0], cap_data[1]); end
    tests++; if (cap_data[4] !== 32'h0000_0000 || cap_data[19] !== 32'h0002_0000 || cap_data[33] !== 32'h0002_000E) begin
      fails++; $display("FAIL sparse_order w4=%h w19=%h w33=%h exp 0/00020000/0002000e", cap_data[4], cap_data[19], cap_data[33]); end
    tests++; if (bad != 0) begin fails++; $display("FAIL sparse_data mismatched_words=%0d exp=0", bad); end
    tests++; if (nl != 1 || lp != 33 + CK) begin fails++; $display("FAIL sparse_tlast count=%0d pos=%0d exp 1/%0d", nl, lp, 33 + CK); end
    exp_seq++;
  endtask

  task automatic test_zero_mask();
    bit to; int bad, nl, lp;
    tile_mask = 4'b0000; cycle_count = 32'h0000_00AA;
    build_expected(4'b0000, 32'h0000_00AA, exp_seq);
    pulse_start();
    capture(100, 0, 100, to);
    bad = 0; nl = 0; lp = -1;
    foreach (cap_data[i]) begin
      if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
      if (cap_last[i]) begin nl++; lp = i; end
    end
    tests++; if (to || cap_data.size() != 4 + CK) begin fails++; $display("FAIL zero_len got=%0d exp=%0d", cap_data.size(), 4 + CK); end
    tests++; if (cap_data[1] !== 32'd0 || cap_data[3] !== 32'd2 || bad != 0) begin fails++; $display("FAIL zero_hdr H1=%0d H3=%0d bad=%0d exp 0/2/0", cap_data[1], cap_data[3], bad); end
    tests++; if (nl != 1 || lp != 3 + CK) begin fails++; $display("FAIL zero_tlast count=%0d pos=%0d exp 1/%0d", nl, lp, 3 + CK); end
    exp_seq++;
  endtask

  task automatic test_backpressure();
    bit to; int bad;
    tile_mask = 4'hF; cycle_count = 32'h0BAD_F00D;
    build_expected(4'hF, 32'h0BAD_F00D, exp_seq);
    pulse_start();
    capture(30, 0, 3000, to);
    bad = 0;
    foreach (cap_data[i]) if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
    tests++; if (to || cap_data.size() != exp_q.size()) begin fails++; $display("FAIL bp_len got=%0d exp=%0d", cap_data.size(), exp_q.size()); end
    tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_stable unstable_cycles=%0d exp=0", stall_err); end
    tests++; if (bad != 0 || cap_data[3] !== 32'd3) begin fails++; $display("FAIL bp_data bad=%0d H3=%0d exp 0/3", bad, cap_data[3]); end
    exp_seq++;
  endtask

  task automatic test_back_to_back();
    bit to; int n, bad; bit got_last; logic [31:0] h3;
    tile_mask = 4'b0000;
    pulse_start();
    n = 0; got_last = 1'b0; h3 = '0;
    for (int c = 0; c < 20 && !got_last; c++) begin
      axis.tready = 1'b1;
      if (axis.tvalid) begin
        if (n == 3) h3 = axis.tdata;
        n++;
        if (axis.tlast) begin
          got_last = 1'b1;
          tile_mask = 4'b1000; cycle_count = 32'h0000_B2B0;
          start = 1'b1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests++; if (!got_last || n != 4 + CK || h3 !== exp_seq) begin fails++; $display("FAIL b2b_first beats=%0d H3=%0d exp %0d/%0d", n, h3, 4 + CK, exp_seq); end
    exp_seq++;
    tests++; if (axis.tvalid !== 1'b0) begin fails++; $display("FAIL b2b_gap tvalid=%b exp=0", axis.tvalid); end
    @(negedge clk);
    tests++; if (axis.tvalid !== 1'b1) begin fails++; $display("FAIL b2b_restart tvalid=%b exp=1", axis.tvalid); end
    build_expected(4'b1000, 32'h0000_B2B0, exp_seq);
    capture(100, 0, 200, to);
    bad = 0;
    foreach (cap_data[i]) if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
    tests++; if (to || cap_data.size() != 19 + CK || bad != 0) begin fails++; $display("FAIL b2b_second len=%0d bad=%0d exp %0d/0", cap_data.size(), bad, 19 + CK); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL b2b_drop got=%0d exp=0", drop_count); end
    exp_seq++;
  endtask

  task automatic test_drop();
    bit to; int bad;
    tile_mask = 4'b0011; cycle_count = 32'h0000_D0D0;
    build_expected(4'b0011, 32'h0000_D0D0, exp_seq);
    pulse_start();
    capture(100, 3, 500, to);
    bad = 0;
    foreach (cap_data[i]) if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
    tests++; if (drop_count !== 16'd3) begin fails++; $display("FAIL drop_count got=%0d exp=3", drop_count); end
    tests++; if (to || cap_data.size() != 34 + CK || bad != 0) begin fails++; $display("FAIL drop_intact len=%0d bad=%0d exp %0d/0", cap_data.size(), bad, 34 + CK); end
    exp_seq++;
    tile_mask = 4'b0000;
    pulse_start();
    capture(100, 0, 100, to);
    tests++; if (to || cap_data[3] !== 32'd7) begin fails++; $display("FAIL drop_next_seq H3=%0d exp=7", cap_data[3]); end
    exp_seq++;
  endtask

  task automatic test_reset_mid();
    bit to; int n, nl, bad; bit hit;
    tile_mask = 4'hF; cycle_count = 32'h0000_0042;
    pulse_start();
    n = 0; nl = 0; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      axis.tready = 1'b1;
      if (axis.tvalid) begin
        if (axis.tlast) nl++;
        n++;
      end
      if (n == 4 + 11) begin
        reset_n = 1'b0;
        hit = 1'b1;
        #1;
      end else begin
        @(negedge clk);
      end
    end
    tests++; if (!hit) begin fails++; $display("FAIL rstmid_reach beats=%0d exp=15", n); end
    tests++; if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || axis.tdata !== 32'h0) begin
      fails++; $display("FAIL rstmid_outputs tvalid=%b tlast=%b tdata=%h exp 0/0/0", axis.tvalid, axis.tlast, axis.tdata); end
    tests++; if (busy !== 1'b0 || drop_count !== 16'd0 || nl != 0) begin fails++; $display("FAIL rstmid_status busy=%b drop=%0d tlasts=%0d exp 0/0/0", busy, drop_count, nl); end
    axis.tready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_seq = '0;
    tile_mask = 4'b0101; cycle_count = 32'h0000_0077;
    build_expected(4'b0101, 32'h0000_0077, exp_seq);
    pulse_start();
    capture(100, 0, 500, to);
    bad = 0;
    foreach (cap_data[i]) if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
    tests++; if (to || cap_data[3] !== 32'd0 || bad != 0) begin fails++; $display("FAIL rstmid_next H3=%0d bad=%0d exp 0/0", cap_data[3], bad); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL rstmid_drop got=%0d exp=0", drop_count); end
    exp_seq++;
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_zero_mask();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
